// File: rtl/pipe_scoreboard.sv
// Register scoreboard for an in-order pipeline: tracks in-flight destination
// registers behind decode and resolves RAW hazards by stalling or bypassing.
// Entry 0 is the youngest (EXE side), entry DEPTH-1 the oldest (WB side).
module pipe_scoreboard #(
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned FWD_MODE    = 0,
    parameter int unsigned LOAD_READY  = 2,
    parameter int unsigned FLUSH_DEPTH = 1,
    localparam int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic                  i_issue_we,
    input  logic                  i_issue_load,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic                  i_rs1_used,
    input  logic                  i_rs2_used,
    input  logic                  i_advance,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic [SEL_W-1:0]      o_fwd_sel1,
    output logic [SEL_W-1:0]      o_fwd_sel2,
    output logic [SEL_W-1:0]      o_pending
);

    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_load;
    logic [REG_ADDR_W-1:0] r_rd [DEPTH];
    logic [SEL_W-1:0]      r_pending;

    logic                  w_hit1, w_hit2;
    logic                  w_blk1, w_blk2;
    logic [SEL_W-1:0]      w_sel1, w_sel2;
    logic                  w_stall;
    logic                  w_admit;
    logic [DEPTH-1:0]      w_valid_nxt;
    logic [DEPTH-1:0]      w_load_nxt;
    logic [REG_ADDR_W-1:0] w_rd_nxt [DEPTH];
    logic [SEL_W-1:0]      w_pending_nxt;

    // Find the youngest matching entry per source; scanning oldest-first lets
    // the lowest index overwrite older hits.
    always_comb begin
        w_hit1 = 1'b0;
        w_blk1 = 1'b0;
        w_sel1 = '0;
        w_hit2 = 1'b0;
        w_blk2 = 1'b0;
        w_sel2 = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (i_rs1_used && (i_rs1 != '0) && r_valid[k] && (r_rd[k] == i_rs1)) begin
                w_hit1 = 1'b1;
                w_blk1 = r_load[k] && (k < int'(LOAD_READY));
                w_sel1 = SEL_W'(k + 1);
            end
            if (i_rs2_used && (i_rs2 != '0) && r_valid[k] && (r_rd[k] == i_rs2)) begin
                w_hit2 = 1'b1;
                w_blk2 = r_load[k] && (k < int'(LOAD_READY));
                w_sel2 = SEL_W'(k + 1);
            end
        end
    end

    // Hazard decision: any match stalls without bypass; with bypass only
    // load data that is not yet available stalls.
    always_comb begin
        if (FWD_MODE == 0) begin
            w_stall = w_hit1 | w_hit2;
        end else begin
            w_stall = w_blk1 | w_blk2;
        end
    end

    assign o_stall    = w_stall;
    assign o_fwd_sel1 = ((FWD_MODE == 0) || w_stall) ? '0 : w_sel1;
    assign o_fwd_sel2 = ((FWD_MODE == 0) || w_stall) ? '0 : w_sel2;
    assign o_pending  = r_pending;

    // Next-state: shift on advance, then kill the youngest entries on flush.
    always_comb begin
        w_admit = i_issue_valid & i_issue_we & ~w_stall & ~i_flush & (i_issue_rd != '0);
        w_valid_nxt = r_valid;
        w_load_nxt  = r_load;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_rd_nxt[k] = r_rd[k];
        end
        if (i_advance) begin
            w_valid_nxt[0] = w_admit;
            w_load_nxt[0]  = i_issue_load;
            w_rd_nxt[0]    = i_issue_rd;
            for (int k = 1; k < int'(DEPTH); k++) begin
                w_valid_nxt[k] = r_valid[k-1];
                w_load_nxt[k]  = r_load[k-1];
                w_rd_nxt[k]    = r_rd[k-1];
            end
        end
        if (i_flush) begin
            for (int k = 0; k < int'(FLUSH_DEPTH) && k < int'(DEPTH); k++) begin
                w_valid_nxt[k] = 1'b0;
            end
        end
        w_pending_nxt = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_pending_nxt = w_pending_nxt + SEL_W'(w_valid_nxt[k]);
        end
    end

    // Entry state and registered occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= '0;
            r_load    <= '0;
            r_pending <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_valid   <= w_valid_nxt;
            r_load    <= w_load_nxt;
            r_pending <= w_pending_nxt;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_rd[k] <= w_rd_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: a stall-only instance and a bypass instance see
// identical stimulus; expected outputs are queued per instance as each cycle
// is driven and popped when the outputs are sampled at mid-cycle.
module tb_pipe_scoreboard;

    typedef struct packed {
        logic       st;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [1:0] p;
    } exp_t;

    typedef struct packed {
        logic       iv;
        logic       we;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] r1;
        logic       u1;
        logic [4:0] r2;
        logic       u2;
        logic       adv;
        logic       fl;
        exp_t       e0;
        exp_t       e1;
    } row_t;

    logic       clk;
    logic       rst_n;
    logic       issue_valid, issue_we, issue_load;
    logic [4:0] issue_rd, rs1, rs2;
    logic       rs1_used, rs2_used, advance, flush;
    logic       stall0, stall1;
    logic [1:0] sel1_0, sel2_0, pend0, sel1_1, sel2_1, pend1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state per instance, used by the random phase.
    logic       mv [2][3];
    logic [4:0] mrd[2][3];
    logic       mld[2][3];

    pipe_scoreboard #(
        .DEPTH(3), .REG_ADDR_W(5), .FWD_MODE(0), .LOAD_READY(2), .FLUSH_DEPTH(1)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_issue_we(issue_we), .i_issue_load(issue_load), .i_rs1(rs1), .i_rs2(rs2),
        .i_rs1_used(rs1_used), .i_rs2_used(rs2_used), .i_advance(advance), .i_flush(flush),
        .o_stall(stall0), .o_fwd_sel1(sel1_0), .o_fwd_sel2(sel2_0), .o_pending(pend0)
    );

    pipe_scoreboard #(
        .DEPTH(3), .REG_ADDR_W(5), .FWD_MODE(1), .LOAD_READY(2), .FLUSH_DEPTH(1)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_issue_we(issue_we), .i_issue_load(issue_load), .i_rs1(rs1), .i_rs2(rs2),
        .i_rs1_used(rs1_used), .i_rs2_used(rs2_used), .i_advance(advance), .i_flush(flush),
        .o_stall(stall1), .o_fwd_sel1(sel1_1), .o_fwd_sel2(sel2_1), .o_pending(pend1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input int iv, we, ld, rd, r1, u1, r2, u2, adv, fl,
                                input int st0, a0, b0, p0, st1, a1, b1, p1);
        row_t r;
        r.iv = iv[0];  r.we = we[0];  r.ld = ld[0];  r.rd = 5'(rd);
        r.r1 = 5'(r1); r.u1 = u1[0];  r.r2 = 5'(r2); r.u2 = u2[0];
        r.adv = adv[0]; r.fl = fl[0];
        r.e0.st = st0[0]; r.e0.s1 = 2'(a0); r.e0.s2 = 2'(b0); r.e0.p = 2'(p0);
        r.e1.st = st1[0]; r.e1.s1 = 2'(a1); r.e1.s2 = 2'(b1); r.e1.p = 2'(p1);
        return r;
    endfunction

    task automatic idle();
        issue_valid = 1'b0; issue_we = 1'b0; issue_load = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        advance = 1'b1; flush = 1'b0;
    endtask

    task automatic drive_row(input row_t r);
        issue_valid = r.iv; issue_we = r.we; issue_load = r.ld; issue_rd = r.rd;
        rs1 = r.r1; rs1_used = r.u1; rs2 = r.r2; rs2_used = r.u2;
        advance = r.adv; flush = r.fl;
    endtask

    // Leaves the bench just after a clock edge with reset released.
    task automatic do_reset();
        idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        rst_n = 1'b0;
        rs1 = 5'd5; rs1_used = 1'b1;
        q0.push_back(exp_t'(0));
        q1.push_back(exp_t'(0));
        #12;
        e = q0.pop_front(); checks++;
        if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
            errors++;
            $display("FAIL reset dut0: got stall=%b sel1=%0d sel2=%0d pend=%0d, want all 0",
                     stall0, sel1_0, sel2_0, pend0);
        end
        e = q1.pop_front(); checks++;
        if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
            errors++;
            $display("FAIL reset dut1: got stall=%b sel1=%0d sel2=%0d pend=%0d, want all 0",
                     stall1, sel1_1, sel2_1, pend1);
        end
    endtask

    // Issue rd=5, then read it: stall-only instance stalls for three cycles,
    // the bypass instance walks the forward select through 1,2,3.
    task automatic test_stall_mode0();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,1,0,5, 0,0,0,0, 1,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(0,0,0,0, 5,1,0,0, 1,0, 1,0,0,1, 0,1,0,1));
        rows.push_back(mk(0,0,0,0, 5,1,0,0, 1,0, 1,0,0,1, 0,2,0,1));
        rows.push_back(mk(0,0,0,0, 5,1,0,0, 1,0, 1,0,0,1, 0,3,0,1));
        rows.push_back(mk(0,0,0,0, 5,1,0,0, 1,0, 0,0,0,0, 0,0,0,0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            q0.push_back(rows[i].e0);
            q1.push_back(rows[i].e1);
            #4;
            e = q0.pop_front(); checks++;
            if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
                errors++;
                $display("FAIL stall_mode0 row%0d dut0: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall0, sel1_0, sel2_0, pend0, e.st, e.s1, e.s2, e.p);
            end
            e = q1.pop_front(); checks++;
            if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
                errors++;
                $display("FAIL stall_mode0 row%0d dut1: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall1, sel1_1, sel2_1, pend1, e.st, e.s1, e.s2, e.p);
            end
            @(posedge clk); #1;
        end
    endtask

    // Non-load bypass on rs2, then x0 and we=0 issues must leave no entry.
    task automatic test_bypass();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,1,0,7, 0,0,0,0,  1,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(0,0,0,0, 0,0,7,1,  1,0, 1,0,0,1, 0,0,1,1));
        rows.push_back(mk(0,0,0,0, 0,0,7,1,  1,0, 1,0,0,1, 0,0,2,1));
        rows.push_back(mk(1,1,0,0, 0,0,0,0,  1,0, 0,0,0,1, 0,0,0,1));
        rows.push_back(mk(1,0,0,13, 0,0,0,0, 1,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(0,0,0,0, 0,1,13,1, 1,0, 0,0,0,0, 0,0,0,0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            q0.push_back(rows[i].e0);
            q1.push_back(rows[i].e1);
            #4;
            e = q0.pop_front(); checks++;
            if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
                errors++;
                $display("FAIL bypass row%0d dut0: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall0, sel1_0, sel2_0, pend0, e.st, e.s1, e.s2, e.p);
            end
            e = q1.pop_front(); checks++;
            if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
                errors++;
                $display("FAIL bypass row%0d dut1: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall1, sel1_1, sel2_1, pend1, e.st, e.s1, e.s2, e.p);
            end
            @(posedge clk); #1;
        end
    endtask

    // Load-use: index 0 and 1 are below LOAD_READY=2, so the bypass instance
    // stalls twice and forwards from index 2. A write offered while stalled
    // must not be admitted.
    task automatic test_load_use();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,1,1,3, 0,0,0,0, 1,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1,1,0,6, 3,1,0,0, 1,0, 1,0,0,1, 1,0,0,1));
        rows.push_back(mk(1,1,0,6, 3,1,0,0, 1,0, 1,0,0,1, 1,0,0,1));
        rows.push_back(mk(1,1,0,6, 3,1,0,0, 1,0, 1,0,0,1, 0,3,0,1));
        rows.push_back(mk(0,0,0,0, 0,0,6,1, 1,0, 0,0,0,0, 0,0,1,1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            q0.push_back(rows[i].e0);
            q1.push_back(rows[i].e1);
            #4;
            e = q0.pop_front(); checks++;
            if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
                errors++;
                $display("FAIL load_use row%0d dut0: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall0, sel1_0, sel2_0, pend0, e.st, e.s1, e.s2, e.p);
            end
            e = q1.pop_front(); checks++;
            if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
                errors++;
                $display("FAIL load_use row%0d dut1: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall1, sel1_1, sel2_1, pend1, e.st, e.s1, e.s2, e.p);
            end
            @(posedge clk); #1;
        end
    endtask

    // rd=4 at index 0 and 2, rd=6 at index 1: youngest wins, x0 and unused
    // sources never match.
    task automatic test_youngest();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,1,0,4, 0,0,0,0, 1,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1,1,0,6, 0,0,0,0, 1,0, 0,0,0,1, 0,0,0,1));
        rows.push_back(mk(1,1,0,4, 0,0,0,0, 1,0, 0,0,0,2, 0,0,0,2));
        rows.push_back(mk(0,0,0,0, 4,1,6,1, 0,0, 1,0,0,3, 0,1,2,3));
        rows.push_back(mk(0,0,0,0, 0,1,6,1, 0,0, 1,0,0,3, 0,0,2,3));
        rows.push_back(mk(0,0,0,0, 4,0,6,0, 0,0, 0,0,0,3, 0,0,0,3));
        rows.push_back(mk(0,0,0,0, 4,1,0,0, 1,0, 1,0,0,3, 0,1,0,3));
        rows.push_back(mk(0,0,0,0, 4,1,0,0, 1,0, 1,0,0,2, 0,2,0,2));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            q0.push_back(rows[i].e0);
            q1.push_back(rows[i].e1);
            #4;
            e = q0.pop_front(); checks++;
            if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
                errors++;
                $display("FAIL youngest row%0d dut0: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall0, sel1_0, sel2_0, pend0, e.st, e.s1, e.s2, e.p);
            end
            e = q1.pop_front(); checks++;
            if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
                errors++;
                $display("FAIL youngest row%0d dut1: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall1, sel1_1, sel2_1, pend1, e.st, e.s1, e.s2, e.p);
            end
            @(posedge clk); #1;
        end
    endtask

    // rd=8 at index 0, rd=9 at index 1; hold four cycles with an issue offered,
    // flush without advance, then flush with advance.
    task automatic test_hold_flush();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,1,0,9,  0,0,0,0,  1,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1,1,0,8,  0,0,0,0,  1,0, 0,0,0,1, 0,0,0,1));
        for (int k = 0; k < 4; k++) begin
            rows.push_back(mk(1,1,0,10, 9,1,8,1, 0,0, 1,0,0,2, 0,2,1,2));
        end
        rows.push_back(mk(1,1,0,11, 9,1,8,1,  0,1, 1,0,0,2, 0,2,1,2));
        rows.push_back(mk(0,0,0,0,  9,1,11,1, 0,0, 1,0,0,1, 0,2,0,1));
        rows.push_back(mk(0,0,0,0,  0,0,8,1,  0,0, 0,0,0,1, 0,0,0,1));
        rows.push_back(mk(1,1,0,12, 9,1,0,0,  1,1, 1,0,0,1, 0,2,0,1));
        rows.push_back(mk(0,0,0,0,  9,1,12,1, 0,0, 1,0,0,1, 0,3,0,1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            q0.push_back(rows[i].e0);
            q1.push_back(rows[i].e1);
            #4;
            e = q0.pop_front(); checks++;
            if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
                errors++;
                $display("FAIL hold_flush row%0d dut0: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall0, sel1_0, sel2_0, pend0, e.st, e.s1, e.s2, e.p);
            end
            e = q1.pop_front(); checks++;
            if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
                errors++;
                $display("FAIL hold_flush row%0d dut1: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall1, sel1_1, sel2_1, pend1, e.st, e.s1, e.s2, e.p);
            end
            @(posedge clk); #1;
        end
    endtask

    // Fill to three entries, pull reset low mid-cycle and check before the
    // next edge, then confirm nothing survives and the first edge works.
    task automatic test_reset_async();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,1,0,1, 0,0,0,0, 1,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1,1,0,2, 0,0,0,0, 1,0, 0,0,0,1, 0,0,0,1));
        rows.push_back(mk(1,1,0,3, 0,0,0,0, 1,0, 0,0,0,2, 0,0,0,2));
        rows.push_back(mk(0,0,0,0, 2,1,0,0, 0,0, 1,0,0,3, 0,2,0,3));
        rows.push_back(mk(1,1,0,2, 2,1,0,0, 1,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(0,0,0,0, 2,1,0,0, 1,0, 1,0,0,1, 0,1,0,1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            q0.push_back(rows[i].e0);
            q1.push_back(rows[i].e1);
            #4;
            e = q0.pop_front(); checks++;
            if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
                errors++;
                $display("FAIL reset_async row%0d dut0: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall0, sel1_0, sel2_0, pend0, e.st, e.s1, e.s2, e.p);
            end
            e = q1.pop_front(); checks++;
            if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
                errors++;
                $display("FAIL reset_async row%0d dut1: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         i, stall1, sel1_1, sel2_1, pend1, e.st, e.s1, e.s2, e.p);
            end
            if (i == 3) begin
                #1;
                rst_n = 1'b0;
                q0.push_back(exp_t'(0));
                q1.push_back(exp_t'(0));
                #1;
                e = q0.pop_front(); checks++;
                if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
                    errors++;
                    $display("FAIL async_clear dut0: got stall=%b pend=%0d, want 0/0",
                             stall0, pend0);
                end
                e = q1.pop_front(); checks++;
                if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
                    errors++;
                    $display("FAIL async_clear dut1: got stall=%b sel1=%0d pend=%0d, want 0/0/0",
                             stall1, sel1_1, pend1);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic exp_t m_eval(input int md);
        exp_t e;
        int   y1, y2, cnt;
        logic l1, l2;
        y1 = -1; y2 = -1; cnt = 0; l1 = 1'b0; l2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (mv[md][k]) cnt++;
            if (y1 < 0 && rs1_used && rs1 != '0 && mv[md][k] && mrd[md][k] == rs1) begin
                y1 = k;
                l1 = mld[md][k];
            end
            if (y2 < 0 && rs2_used && rs2 != '0 && mv[md][k] && mrd[md][k] == rs2) begin
                y2 = k;
                l2 = mld[md][k];
            end
        end
        e.p = 2'(cnt);
        if (md == 0) begin
            e.st = (y1 >= 0) || (y2 >= 0);
            e.s1 = 2'd0;
            e.s2 = 2'd0;
        end else begin
            e.st = (l1 && y1 < 2) || (l2 && y2 < 2);
            e.s1 = (e.st || y1 < 0) ? 2'd0 : 2'(y1 + 1);
            e.s2 = (e.st || y2 < 0) ? 2'd0 : 2'(y2 + 1);
        end
        return e;
    endfunction

    task automatic m_step(input int md, input logic st);
        logic adm;
        adm = issue_valid && issue_we && !st && !flush && (issue_rd != '0);
        if (advance) begin
            for (int k = 2; k >= 1; k--) begin
                mv[md][k] = mv[md][k-1]; mrd[md][k] = mrd[md][k-1]; mld[md][k] = mld[md][k-1];
            end
            mv[md][0] = adm; mrd[md][0] = issue_rd; mld[md][0] = issue_load;
        end
        if (flush) mv[md][0] = 1'b0;
    endtask

    task automatic test_random();
        exp_t e, x0, x1;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) begin
                mv[m][k] = 1'b0; mrd[m][k] = '0; mld[m][k] = 1'b0;
            end
        end
        for (int n = 0; n < 300; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_we    = ($urandom_range(0, 3) != 0);
            issue_load  = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            rs1_used    = ($urandom_range(0, 3) != 0);
            rs2_used    = ($urandom_range(0, 3) != 0);
            advance     = ($urandom_range(0, 4) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            x0 = m_eval(0);
            x1 = m_eval(1);
            q0.push_back(x0);
            q1.push_back(x1);
            #4;
            e = q0.pop_front(); checks++;
            if ({stall0, sel1_0, sel2_0, pend0} !== e) begin
                errors++;
                $display("FAIL random cyc%0d dut0: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         n, stall0, sel1_0, sel2_0, pend0, e.st, e.s1, e.s2, e.p);
            end
            e = q1.pop_front(); checks++;
            if ({stall1, sel1_1, sel2_1, pend1} !== e) begin
                errors++;
                $display("FAIL random cyc%0d dut1: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         n, stall1, sel1_1, sel2_1, pend1, e.st, e.s1, e.s2, e.p);
            end
            m_step(0, x0.st);
            m_step(1, x1.st);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stall_mode0();
        test_bypass();
        test_load_use();
        test_youngest();
        test_hold_flush();
        test_reset_async();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
